// File: rtl/egress_capture_buffer.sv
// Per-port circular capture buffers for fabric egress streams, drained by the host
// through an Avalon-MM window (pop, occupancy, drop count, write pointer, flush).
module egress_capture_buffer #(
  parameter int          NPORTS       = 3,
  parameter int          DATA_W       = 32,
  parameter int          DEPTH_LOG2   = 12,
  parameter int          DROP_ZERO    = 1,
  parameter logic [31:0] EMPTY_WORD   = 32'hFF,
  parameter logic [31:0] IDLE_WORD    = 32'hFB,
  parameter logic [31:0] BADADDR_WORD = 32'hFC
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NPORTS-1:0]        in_valid,
  input  logic [NPORTS*DATA_W-1:0] in_data,
  input  logic                     chipselect,
  input  logic                     read,
  input  logic                     write,
  input  logic [5:0]               address,
  input  logic [31:0]              writedata,
  output logic [31:0]              readdata,
  output logic [NPORTS-1:0]        full,
  output logic [NPORTS-1:0]        empty
);

  localparam int                  DEPTH      = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT  = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0] ONE_CNT    = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2-1:0] ONE_PTR  = DEPTH_LOG2'(1);
  localparam logic [4:0]          NPORTS_CNT = 5'(NPORTS);

  logic       rd_acc_s;
  logic       wr_acc_s;
  logic       port_ok_s;
  logic [1:0] group_s;
  logic [3:0] port_s;
  logic       unused_s;

  assign group_s   = address[5:4];
  assign port_s    = address[3:0];
  assign rd_acc_s  = chipselect & read;
  assign wr_acc_s  = chipselect & write & ~read;
  assign port_ok_s = ({1'b0, port_s} < NPORTS_CNT);
  assign unused_s  = ^writedata;

  logic [NPORTS-1:0]                 head_vld_a;
  logic [NPORTS-1:0][DATA_W-1:0]     head_a;
  logic [NPORTS-1:0][DEPTH_LOG2:0]   count_a;
  logic [NPORTS-1:0][15:0]           ovf_a;
  logic [NPORTS-1:0][DEPTH_LOG2-1:0] wr_ptr_a;

  for (genvar p = 0; p < NPORTS; p++) begin : g_port
    logic [DATA_W-1:0]     mem_r [DEPTH];
    logic [DATA_W-1:0]     word_s;
    logic [DATA_W-1:0]     head_r;
    logic [DEPTH_LOG2-1:0] wr_ptr_r;
    logic [DEPTH_LOG2-1:0] rd_ptr_r;
    logic [DEPTH_LOG2-1:0] rd_next_s;
    logic [DEPTH_LOG2:0]   count_r;
    logic [DEPTH_LOG2:0]   count_next_s;
    logic [15:0]           ovf_r;
    logic                  head_vld_r;
    logic                  head_vld_next_s;
    logic                  pop_s;
    logic                  flush_s;
    logic                  push_req_s;
    logic                  push_acc_s;
    logic                  drop_s;
    logic                  full_r;
    logic                  empty_r;

    assign word_s  = in_data[p*DATA_W +: DATA_W];
    assign pop_s   = rd_acc_s && (group_s == 2'd0) && (port_s == 4'(p)) && head_vld_r;
    assign flush_s = wr_acc_s && (group_s == 2'd3) && (port_s == 4'(p));

    // Push/drop arbitration and next pointer/count; the head is only valid once its RAM read has landed.
    always_comb begin
      push_req_s      = in_valid[p] && !((DROP_ZERO != 0) && (word_s == {DATA_W{1'b0}}));
      push_acc_s      = 1'b0;
      drop_s          = 1'b0;
      rd_next_s       = rd_ptr_r;
      count_next_s    = count_r;
      head_vld_next_s = 1'b0;
      if (flush_s) begin
        rd_next_s    = {DEPTH_LOG2{1'b0}};
        count_next_s = {(DEPTH_LOG2+1){1'b0}};
      end else begin
        if (push_req_s) begin
          if ((count_r != DEPTH_CNT) || pop_s) begin
            push_acc_s = 1'b1;
          end else begin
            drop_s = 1'b1;
          end
        end else begin
          push_acc_s = 1'b0;
        end
        if (pop_s) begin
          rd_next_s = rd_ptr_r + ONE_PTR;
        end else begin
          rd_next_s = rd_ptr_r;
        end
        case ({push_acc_s, pop_s})
          2'b10:   count_next_s = count_r + ONE_CNT;
          2'b01:   count_next_s = count_r - ONE_CNT;
          default: count_next_s = count_r;
        endcase
      end
      head_vld_next_s = (count_next_s != {(DEPTH_LOG2+1){1'b0}}) &&
                        !(push_acc_s && (wr_ptr_r == rd_next_s));
    end

    // Capture RAM: read-first, the read port always prefetches the next head.
    always_ff @(posedge clk) begin
      if (push_acc_s) begin
        mem_r[wr_ptr_r] <= word_s;
      end
      head_r <= mem_r[rd_next_s];
    end

    // Pointer, occupancy, drop-counter and status flag state.
    always_ff @(posedge clk) begin
      if (reset) begin
        wr_ptr_r   <= {DEPTH_LOG2{1'b0}};
        rd_ptr_r   <= {DEPTH_LOG2{1'b0}};
        count_r    <= {(DEPTH_LOG2+1){1'b0}};
        ovf_r      <= 16'h0000;
        head_vld_r <= 1'b0;
        full_r     <= 1'b0;
        empty_r    <= 1'b1;
      end else begin
        rd_ptr_r   <= rd_next_s;
        count_r    <= count_next_s;
        head_vld_r <= head_vld_next_s;
        full_r     <= (count_next_s == DEPTH_CNT);
        empty_r    <= (count_next_s == {(DEPTH_LOG2+1){1'b0}});
        if (flush_s) begin
          wr_ptr_r <= {DEPTH_LOG2{1'b0}};
          ovf_r    <= 16'h0000;
        end else begin
          if (push_acc_s) begin
            wr_ptr_r <= wr_ptr_r + ONE_PTR;
          end
          if (drop_s && (ovf_r != 16'hFFFF)) begin
            ovf_r <= ovf_r + 16'd1;
          end
        end
      end
    end

    assign head_vld_a[p] = head_vld_r;
    assign head_a[p]     = head_r;
    assign count_a[p]    = count_r;
    assign ovf_a[p]      = ovf_r;
    assign wr_ptr_a[p]   = wr_ptr_r;
    assign full[p]       = full_r;
    assign empty[p]      = empty_r;
  end

  logic                  sel_head_vld_s;
  logic [DATA_W-1:0]     sel_head_s;
  logic [DEPTH_LOG2:0]   sel_count_s;
  logic [15:0]           sel_ovf_s;
  logic [DEPTH_LOG2-1:0] sel_wr_ptr_s;
  logic [31:0]           rd_word_s;

  // Register-window read mux over the addressed port.
  always_comb begin
    sel_head_vld_s = 1'b0;
    sel_head_s     = {DATA_W{1'b0}};
    sel_count_s    = {(DEPTH_LOG2+1){1'b0}};
    sel_ovf_s      = 16'h0000;
    sel_wr_ptr_s   = {DEPTH_LOG2{1'b0}};
    for (int i = 0; i < NPORTS; i++) begin
      sel_head_vld_s = sel_head_vld_s | ((port_s == 4'(i)) & head_vld_a[i]);
      sel_head_s     = sel_head_s   | ({DATA_W{port_s == 4'(i)}} & head_a[i]);
      sel_count_s    = sel_count_s  | ({(DEPTH_LOG2+1){port_s == 4'(i)}} & count_a[i]);
      sel_ovf_s      = sel_ovf_s    | ({16{port_s == 4'(i)}} & ovf_a[i]);
      sel_wr_ptr_s   = sel_wr_ptr_s | ({DEPTH_LOG2{port_s == 4'(i)}} & wr_ptr_a[i]);
    end
    rd_word_s = BADADDR_WORD;
    if (port_ok_s) begin
      case (group_s)
        2'd0:    rd_word_s = sel_head_vld_s ? 32'(sel_head_s) : EMPTY_WORD;
        2'd1:    rd_word_s = 32'(sel_count_s);
        2'd2:    rd_word_s = {16'h0000, sel_ovf_s};
        2'd3:    rd_word_s = 32'(sel_wr_ptr_s);
        default: rd_word_s = BADADDR_WORD;
      endcase
    end else begin
      rd_word_s = BADADDR_WORD;
    end
  end

  // Fixed latency-1 read data; idle cycles present the idle marker.
  always_ff @(posedge clk) begin
    if (reset) begin
      readdata <= IDLE_WORD;
    end else if (rd_acc_s) begin
      readdata <= rd_word_s;
    end else begin
      readdata <= IDLE_WORD;
    end
  end

endmodule
